// File: rtl/adc_ddr_rx_align.sv
// Receiver for one 14-bit ADC channel carried on 7 DDR lanes.
// Reassembles each sample from rising/falling lane captures, undoes the ADC's
// bit inversion, and runs a training FSM that picks the rise/fall pairing
// (slip) by searching for a known pattern before declaring data valid.
module adc_ddr_rx_align #(
    parameter int              DW        = 14,
    parameter logic [DW-1:0]   TRAIN_PAT = 14'h1A5C,
    parameter int              TRAIN_LEN = 16,
    parameter int              WIN       = 64,
    parameter int              MAX_TRY   = 4
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rst_i,
    input  logic [DW/2-1:0]      ddr_rise_i,
    input  logic [DW/2-1:0]      ddr_fall_i,
    input  logic                 train_i,
    output logic signed [DW-1:0] adc_dat_o,
    output logic                 adc_dv_o,
    output logic                 locked_o,
    output logic                 fail_o,
    output logic                 slip_o,
    output logic [2:0]           try_cnt_o
);

    localparam int LANES   = DW / 2;
    localparam int WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int MATCH_W = $clog2(TRAIN_LEN + 1);

    typedef enum logic [2:0] {IDLE, CHECK, FLUSH, LOCKED, FAIL} state_t;

    state_t               state;
    logic [LANES-1:0]     rise_p0;
    logic [LANES-1:0]     fall_p0;
    logic [LANES-1:0]     rise_p1;
    logic [DW-1:0]        word;
    logic [WIN_W-1:0]     win_cnt;
    logic [MATCH_W-1:0]   match_cnt;
    logic [MATCH_W-1:0]   match_nxt;
    logic                 flush_cnt;

    // ADC sends the MSB straight and bits below it inverted; flipping them back
    // yields the two's-complement sample.
    function automatic logic signed [DW-1:0] decode_word(input logic [DW-1:0] w);
        return {w[DW-1], ~w[DW-2:0]};
    endfunction

    // Lane capture stage plus a one-cycle-delayed copy of the rising bits,
    // which is used when the falling half arrives a cycle after its rising half.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            rise_p0 <= '0;
            fall_p0 <= '0;
            rise_p1 <= '0;
        end else begin
            rise_p0 <= ddr_rise_i;
            fall_p0 <= ddr_fall_i;
            rise_p1 <= rise_p0;
        end
    end

    // Interleave lanes into a raw word: even bits from rise, odd bits from fall.
    always_comb begin
        word = '0;
        for (int i = 0; i < LANES; i++) begin
            word[2*i]   = slip_o ? rise_p1[i] : rise_p0[i];
            word[2*i+1] = fall_p0[i];
        end
    end

    // Decode stage, updated every cycle regardless of training state.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            adc_dat_o <= '0;
        end else begin
            adc_dat_o <= decode_word(word);
        end
    end

    // Run length of consecutive pattern hits including the sample now on adc_dat_o.
    always_comb begin
        match_nxt = '0;
        if ($unsigned(adc_dat_o) == TRAIN_PAT) begin
            match_nxt = match_cnt + 1'b1;
        end
    end

    // Training FSM: search each window for a pattern run, toggle slip between
    // attempts, and give up after MAX_TRY windows.
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            state     <= IDLE;
            slip_o    <= 1'b0;
            try_cnt_o <= '0;
            win_cnt   <= '0;
            match_cnt <= '0;
            flush_cnt <= 1'b0;
            locked_o  <= 1'b0;
            fail_o    <= 1'b0;
            adc_dv_o  <= 1'b0;
        end else if (train_i) begin
            state     <= CHECK;
            try_cnt_o <= '0;
            win_cnt   <= '0;
            match_cnt <= '0;
            flush_cnt <= 1'b0;
            locked_o  <= 1'b0;
            fail_o    <= 1'b0;
            adc_dv_o  <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    win_cnt   <= win_cnt + 1'b1;
                    match_cnt <= match_nxt;
                    if (match_nxt == MATCH_W'(TRAIN_LEN)) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                        adc_dv_o <= 1'b1;
                    end else if (win_cnt == WIN_W'(WIN - 1)) begin
                        try_cnt_o <= try_cnt_o + 3'd1;
                        if (try_cnt_o + 3'd1 == 3'(MAX_TRY)) begin
                            state  <= FAIL;
                            fail_o <= 1'b1;
                        end else begin
                            slip_o    <= ~slip_o;
                            state     <= FLUSH;
                            flush_cnt <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // Two cycles let samples built with the new pairing reach adc_dat_o.
                    win_cnt   <= '0;
                    match_cnt <= '0;
                    if (flush_cnt) begin
                        state <= CHECK;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
